// File: rtl/riscv_pkg.sv
// RV32M op encodings and muldiv FSM states shared by the EX stage.
// Op codes follow the funct3 field of the M-extension instructions.
package riscv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 RV32M mul/div: XLEN+1 cycles from accept to rsp_valid_o, 1 cycle for div-by-zero/overflow.
// One op in flight; result held in DONE until rsp_ready_i, no accepts outside IDLE; flush kills.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            flush_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         r_state, w_state_nxt;
  logic [2:0]        r_op;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic              r_neg_q, r_neg_r;
  logic [XLEN-1:0]   r_result;

  logic              w_accept, w_is_div, w_sign1, w_sign2, w_div0, w_ovf, w_special;
  logic [XLEN-1:0]   w_mag1, w_mag2, w_special_res;
  logic [XLEN:0]     w_mul_sum, w_div_pr, w_div_diff;
  logic [2*XLEN-1:0] w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
  logic [XLEN-1:0]   w_quot, w_rem, w_final;
  logic              w_div_ok, w_last;

  assign w_accept = (r_state == MD_IDLE) && req_valid_i && !flush_i;
  assign w_is_div = op_i[2];
  assign w_sign1  = op1_i[XLEN-1] && (op_i == MD_MULH || op_i == MD_MULHSU ||
                                      op_i == MD_DIV  || op_i == MD_REM);
  assign w_sign2  = op2_i[XLEN-1] && (op_i == MD_MULH || op_i == MD_DIV || op_i == MD_REM);
  assign w_mag1   = w_sign1 ? -op1_i : op1_i;
  assign w_mag2   = w_sign2 ? -op2_i : op2_i;

  assign w_div0    = w_is_div && (op2_i == '0);
  assign w_ovf     = (op_i == MD_DIV || op_i == MD_REM) && (op1_i == MIN_NEG) && (op2_i == '1);
  assign w_special = w_div0 || w_ovf;
  // op_i[1] separates REM/REMU from DIV/DIVU
  assign w_special_res = w_div0 ? (op_i[1] ? op1_i : '1) : (op_i[1] ? '0 : MIN_NEG);

  // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: {remainder, dividend/quotient} shifts left, quotient bits enter at bit 0.
  assign w_div_pr   = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_diff = w_div_pr - {1'b0, r_b};
  assign w_div_ok   = !w_div_diff[XLEN];
  assign w_div_nxt  = {(w_div_ok ? w_div_diff[XLEN-1:0] : w_div_pr[XLEN-1:0]),
                       r_acc[XLEN-2:0], w_div_ok};

  assign w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;
  assign w_last    = (r_cnt == CW'(XLEN - 1));
  assign w_prod    = r_neg_q ? -w_acc_nxt : w_acc_nxt;
  assign w_quot    = r_neg_q ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
  assign w_rem     = r_neg_r ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];

  always_comb begin
    w_final = w_rem;
    case (r_op)
      MD_MUL:                       w_final = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              w_final = w_quot;
      MD_REM, MD_REMU:              w_final = w_rem;
      default:                      w_final = w_rem;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= MD_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = (r_state == MD_IDLE);
    rsp_valid_o = (r_state == MD_DONE);
    case (r_state)
      MD_IDLE: if (w_accept) w_state_nxt = w_special ? MD_DONE : MD_CALC;
      MD_CALC: if (w_last) w_state_nxt = MD_DONE;
      MD_DONE: if (rsp_ready_i) w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
    if (flush_i) w_state_nxt = MD_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op    <= op_i;
      r_cnt   <= '0;
      r_neg_q <= w_sign1 ^ w_sign2;
      r_neg_r <= w_sign1;
      r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
      r_b     <= w_is_div ? w_mag2 : w_mag1;
      if (w_special) r_result <= w_special_res;
    end else if (r_state == MD_CALC && !flush_i) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_result <= w_final;
    end
  end

  assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized ops vs. an arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op;
  logic [31:0] op1, op2;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] result;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .op_i        (op),
    .op1_i       (op1),
    .op2_i       (op2),
    .flush_i     (flush),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .result_o    (result)
  );

  // Reference: plain 64-bit arithmetic, RISC-V divide-by-zero rules.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p = '0;
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Presents one op (caller is one #1 past an edge, unit idle) and waits for the response.
  // lat counts edges from the accepting edge (1) to the edge after which rsp_valid is seen.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit busy_rdy);
    req_valid = 1'b1;
    op = o; op1 = a; op2 = b;
    lat = 0;
    busy_rdy = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) req_valid = 1'b0;
      if (!rsp_valid && req_ready) busy_rdy = 1'b1;
    end while (!rsp_valid && lat < 200);
    res = result;
    if (rsp_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; op = '0; op1 = '0; op2 = '0; flush = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    n_total++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    n_total++; if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result got=%h want=0", result); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_latency();
    logic [31:0] r; int lat; bit busy;
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, r, lat, busy);
    n_total++; if (r !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL mul_result got=%h want=ffffffeb", r); end
    n_total++; if (lat != 33) begin n_bad++; $display("FAIL mul_latency got=%0d want=33", lat); end
    n_total++; if (busy) begin n_bad++; $display("FAIL mul_ready_busy got=1 want=0"); end
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [10] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd6};
    logic [31:0] t_a  [10] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFEC, 32'hFFFFFFEC,
                               32'd20, 32'd20, 32'd5, 32'd5, 32'h80000000};
    logic [31:0] t_b  [10] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'd3,
                               32'd3, 32'd3, 32'd0, 32'd0, 32'hFFFFFFFF};
    logic [31:0] t_exp[10] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFE,
                               32'd6, 32'd2, 32'hFFFFFFFF, 32'd5, 32'd0};
    int          t_lat[10] = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 1};
    logic [31:0] r; int lat; bit busy;
    for (int i = 0; i < 10; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], r, lat, busy);
      n_total++;
      if (r !== t_exp[i]) begin n_bad++; $display("FAIL directed_result[%0d] got=%h want=%h", i, r, t_exp[i]); end
      n_total++;
      if (lat != t_lat[i]) begin n_bad++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, t_lat[i]); end
    end
    // overflow DIV not in the table above
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, r, lat, busy);
    n_total++; if (r !== 32'h80000000 || lat != 1) begin
      n_bad++; $display("FAIL div_overflow got=%h/%0d want=80000000/1", r, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r, held; int lat; bit busy;
    rsp_ready = 1'b0;
    run_op(3'd5, 32'd100, 32'd7, r, lat, busy);
    held = r;
    n_total++; if (r !== 32'd14) begin n_bad++; $display("FAIL bp_result got=%h want=e", r); end
    req_valid = 1'b1; op = 3'd3; op1 = 32'hFFFFFFFF; op2 = 32'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (rsp_valid !== 1'b1 || result !== held || req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d] got v=%b r=%h rdy=%b want v=1 r=%h rdy=0", i, rsp_valid, result, req_ready, held);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_idle got rdy=%b v=%b want rdy=1 v=0", req_ready, rsp_valid);
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) req_valid = 1'b0;
    end while (!rsp_valid && lat < 200);
    n_total++; if (result !== ref_model(3'd3, 32'hFFFFFFFF, 32'd2) || lat != 33) begin
      n_bad++; $display("FAIL bp_held_req got=%h/%0d want=%h/33", result, lat, ref_model(3'd3, 32'hFFFFFFFF, 32'd2));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    logic [31:0] r; int lat; bit busy, seen;
    req_valid = 1'b1; op = 3'd5; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_calc got rdy=%b v=%b want rdy=1 v=0", req_ready, rsp_valid);
    end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    n_total++; if (seen) begin n_bad++; $display("FAIL flush_no_rsp got=1 want=0"); end
    // request coincident with flush must be dropped
    req_valid = 1'b1; flush = 1'b1; op = 3'd4; op1 = 32'd5; op2 = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    n_total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_idle_req got rdy=%b v=%b want rdy=1 v=0", req_ready, rsp_valid);
    end
    run_op(3'd6, 32'hFFFFFFEC, 32'd3, r, lat, busy);
    n_total++; if (r !== 32'hFFFFFFFE || lat != 33) begin
      n_bad++; $display("FAIL flush_next got=%h/%0d want=fffffffe/33", r, lat);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    req_valid = 1'b1; op = 3'd0; op1 = 32'd3; op2 = 32'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || result !== 32'h0) begin
      n_bad++; $display("FAIL async_reset got rdy=%b v=%b r=%h want rdy=1 v=0 r=0", req_ready, rsp_valid, result);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    n_total++; if (seen) begin n_bad++; $display("FAIL async_reset_no_rsp got=1 want=0"); end
  endtask

  task automatic test_random();
    logic [31:0] r, a, b; logic [2:0] o; int lat; bit busy;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = rand_operand();
      b = rand_operand();
      run_op(o, a, b, r, lat, busy);
      n_total++;
      if (r !== ref_model(o, a, b) || lat != exp_latency(o, a, b)) begin
        n_bad++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h/%0d want=%h/%0d",
                 i, o, a, b, r, lat, ref_model(o, a, b), exp_latency(o, a, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_latency();
    test_directed();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
